glip_uart_tx_scheduler: RTL and testbench

GLIP_UART_TX_SCHEDULER -- requirements
Module: glip_uart_tx_scheduler

---
 rtl/glip_uart_pkg.sv | 21 ++
 rtl/glip_uart_tx_scheduler.sv | 116 +++++++++++
 tb/tb_glip_uart_tx_scheduler.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/glip_uart_pkg.sv
// Shared definitions for the GLIP UART egress path.
//   ESCAPE_DEFAULT : marker byte that opens a credit message and is doubled
//                    when it appears in payload data.
//   state_t / ST_* : scheduler FSM encoding.
//   CRED_W         : internal width of a latched credit count.
package glip_uart_pkg;

  localparam logic [7:0] ESCAPE_DEFAULT = 8'hFE;

  localparam int CRED_W = 14;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_DATA     = 3'd1;
  localparam state_t ST_DATA_ESC = 3'd2;
  localparam state_t ST_CRED_HDR = 3'd3;
  localparam state_t ST_CRED_HI  = 3'd4;
  localparam state_t ST_CRED_LO  = 3'd5;

endpackage

// File: rtl/glip_uart_tx_scheduler.sv
// Egress byte scheduler between out_fifo and glip_uart_transmit.
// Arbitrates between payload bytes and credit messages (credit has fixed
// priority), escapes payload bytes equal to ESCAPE by doubling them, and
// frames credit counts as ESCAPE, {0,credit[13:7]}, {0,credit[6:0]}.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   data_in_data/valid/ready   FWFT payload source; ready is the pop strobe
//   credit_req/value/ack       credit message request (level), count, done pulse
//   tx_data/enable/done/hold   byte transmitter handshake, hold = CTS stop
//   busy                       FSM not idle
module glip_uart_tx_scheduler
  import glip_uart_pkg::*;
#(
  parameter int         CREDIT_WIDTH = 12,
  parameter logic [7:0] ESCAPE       = ESCAPE_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7:0]              data_in_data,
  input  logic                    data_in_valid,
  output logic                    data_in_ready,
  input  logic                    credit_req,
  input  logic [CREDIT_WIDTH-1:0] credit_value,
  output logic                    credit_ack,
  output logic [7:0]              tx_data,
  output logic                    tx_enable,
  input  logic                    tx_done,
  input  logic                    tx_hold,
  output logic                    busy
);

  state_t            state_q, state_d;
  logic [7:0]        byte_q, byte_d;
  logic [CRED_W-1:0] cred_q, cred_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              en_q, en_d;
  logic              grant_data;
  logic              byte_done;

  always_comb begin
    state_d    = state_q;
    byte_d     = byte_q;
    cred_d     = cred_q;
    tx_data_d  = tx_data_q;
    en_d       = en_q;
    grant_data = 1'b0;
    // tx_done only counts while a byte is actually requested
    byte_done  = en_q & tx_done;

    if (state_q == ST_IDLE) begin
      // rst_n gate keeps the pop strobe low while reset is held
      if (!tx_hold && rst_n) begin
        if (credit_req) begin
          cred_d    = CRED_W'(credit_value);
          tx_data_d = ESCAPE;
          state_d   = ST_CRED_HDR;
        end else if (data_in_valid) begin
          grant_data = 1'b1;
          byte_d     = data_in_data;
          tx_data_d  = data_in_data;
          state_d    = ST_DATA;
        end
      end
    end else if (byte_done) begin
      // Next byte is loaded here; en drops for the entry cycle of the
      // next state, which gives the mandatory gap between requests.
      en_d = 1'b0;
      case (state_q)
        ST_DATA: begin
          if (byte_q == ESCAPE) begin
            tx_data_d = ESCAPE;
            state_d   = ST_DATA_ESC;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_CRED_HDR: begin
          tx_data_d = {1'b0, cred_q[13:7]};
          state_d   = ST_CRED_HI;
        end
        ST_CRED_HI: begin
          tx_data_d = {1'b0, cred_q[6:0]};
          state_d   = ST_CRED_LO;
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (!en_q && !tx_hold) begin
      // hold is only consulted before starting a byte
      en_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      byte_q    <= 8'h00;
      cred_q    <= '0;
      tx_data_q <= 8'h00;
      en_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      byte_q    <= byte_d;
      cred_q    <= cred_d;
      tx_data_q <= tx_data_d;
      en_q      <= en_d;
    end
  end

  assign data_in_ready = grant_data;
  assign credit_ack    = byte_done && (state_q == ST_CRED_LO);
  assign tx_data       = tx_data_q;
  assign tx_enable     = en_q;
  assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_glip_uart_tx_scheduler.sv
// Bench for glip_uart_tx_scheduler: vector table, hand-written corner
// sequences and randomized batches against an event-stream model.
// Events: byte sent = byte value, pop strobe = EV_R, credit ack = EV_A.
module tb_glip_uart_tx_scheduler;

  localparam int CW   = 12;
  localparam int EV_R = 'h100;
  localparam int EV_A = 'h200;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    data_in_data;
  logic          data_in_valid;
  logic          data_in_ready;
  logic          credit_req;
  logic [CW-1:0] credit_value;
  logic          credit_ack;
  logic [7:0]    tx_data;
  logic          tx_enable;
  logic          tx_done;
  logic          tx_hold;
  logic          busy;

  glip_uart_tx_scheduler #(.CREDIT_WIDTH(CW), .ESCAPE(8'hFE)) dut (
    .clk(clk), .rst_n(rst_n),
    .data_in_data(data_in_data), .data_in_valid(data_in_valid),
    .data_in_ready(data_in_ready),
    .credit_req(credit_req), .credit_value(credit_value),
    .credit_ack(credit_ack),
    .tx_data(tx_data), .tx_enable(tx_enable), .tx_done(tx_done),
    .tx_hold(tx_hold), .busy(busy)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         ev_q[$];
  int         exp_q[$];
  logic [7:0] dq[$];
  int         cq[$];
  bit         pop_d = 0, pop_c = 0;
  int         dly = 2;
  bit         spur = 0;
  bit         hold_rand = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // model: a payload byte is popped then sent, doubled if it is the marker
  function automatic void exp_data(input int b);
    exp_q.push_back(EV_R);
    exp_q.push_back(b);
    if (b == 'hFE) exp_q.push_back(b);
  endfunction

  // model: credit message is marker, high 7 bits, low 7 bits, then ack
  function automatic void exp_cred(input int c);
    exp_q.push_back('hFE);
    exp_q.push_back((c / 128) % 128);
    exp_q.push_back(c % 128);
    exp_q.push_back(EV_A);
  endfunction

  task automatic compare_ev(input string nm);
    int n;
    chk({nm, "_count"}, ev_q.size(), exp_q.size());
    n = (ev_q.size() < exp_q.size()) ? ev_q.size() : exp_q.size();
    for (int k = 0; k < n; k++) chk($sformatf("%s_ev%0d", nm, k), ev_q[k], exp_q[k]);
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (!(dq.size() == 0 && cq.size() == 0 && !busy && !pop_d && !pop_c)) begin
      @(negedge clk);
      n++;
      if (n > 4000) begin
        chk({nm, "_timeout"}, 0, 1);
        return;
      end
    end
    repeat (3) @(negedge clk);
  endtask

  // monitor: samples outputs on the falling edge
  logic prev_en = 1'b0;
  logic [7:0] prev_dat = 8'h00;
  int last_rise = -100;
  always @(negedge clk) begin
    cyc++;
    if (data_in_ready) begin ev_q.push_back(EV_R); pop_d = 1; end
    if (credit_ack)    begin ev_q.push_back(EV_A); pop_c = 1; end
    if (tx_enable && !prev_en) begin
      chk("en_spacing_ok", int'(cyc - last_rise >= 2), 1);
      last_rise = cyc;
    end
    if (tx_enable && prev_en) chk("tx_data_stable", tx_data, prev_dat);
    prev_en  = tx_enable;
    prev_dat = tx_data;
  end

  // transmitter model: tx_done dly cycles after enable is first seen
  int cnt = 0;
  initial begin
    tx_done = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n || tx_done) begin
        tx_done = 1'b0;
        cnt = 0;
      end else if (tx_enable) begin
        if (cnt >= dly) begin
          tx_done = 1'b1;
          ev_q.push_back(int'(tx_data));
        end else cnt++;
      end else if (spur) begin
        tx_done = 1'b1;
      end
    end
  end

  // FWFT data source and credit requester fed from queues
  initial begin
    data_in_valid = 0; data_in_data = 0; credit_req = 0; credit_value = 0;
    forever begin
      @(posedge clk); #1;
      if (pop_d) begin pop_d = 0; if (dq.size() > 0) dq.delete(0); end
      if (pop_c) begin pop_c = 0; if (cq.size() > 0) cq.delete(0); end
      data_in_valid = (dq.size() > 0);
      data_in_data  = (dq.size() > 0) ? dq[0] : 8'h00;
      credit_req    = (cq.size() > 0);
      credit_value  = (cq.size() > 0) ? CW'(cq[0]) : '0;
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (hold_rand) tx_hold = ($urandom_range(0, 2) == 0);
    end
  end

  typedef struct {
    bit is_cred;
    int val;
    int d;
    int n;
    int e0, e1, e2, e3;
  } vec_t;

  vec_t vt[8];

  initial begin
    int n;
    int nc, nd, v;
    tx_hold = 0;
    vt[0] = '{0, 'h41,  10, 2, EV_R, 'h41, 0, 0};
    vt[1] = '{0, 'hFE,  3,  3, EV_R, 'hFE, 'hFE, 0};
    vt[2] = '{1, 'hABC, 2,  4, 'hFE, 'h15, 'h3C, EV_A};
    vt[3] = '{1, 'h000, 0,  4, 'hFE, 'h00, 'h00, EV_A};
    vt[4] = '{1, 'hFFF, 1,  4, 'hFE, 'h1F, 'h7F, EV_A};
    vt[5] = '{0, 'h00,  0,  2, EV_R, 'h00, 0, 0};
    vt[6] = '{1, 'h080, 4,  4, 'hFE, 'h01, 'h00, EV_A};
    vt[7] = '{0, 'hFD,  5,  2, EV_R, 'hFD, 0, 0};

    // reset state, with a byte already waiting at the source
    dq.push_back(8'h11);
    repeat (3) @(negedge clk);
    chk("rst_tx_enable", tx_enable, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", data_in_ready, 0);
    chk("rst_ack", credit_ack, 0);
    ev_q.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("first_arb_ready", data_in_ready, 1);
    @(negedge clk);
    chk("first_arb_busy", busy, 1);
    wait_idle("first");
    exp_q.delete(); exp_data('h11);
    compare_ev("first");

    // vector table
    foreach (vt[i]) begin
      ev_q.delete(); exp_q.delete();
      dly = vt[i].d;
      if (vt[i].is_cred) cq.push_back(vt[i].val);
      else dq.push_back(8'(vt[i].val));
      wait_idle("vec");
      for (int k = 0; k < vt[i].n; k++)
        exp_q.push_back(k == 0 ? vt[i].e0 : k == 1 ? vt[i].e1 : k == 2 ? vt[i].e2 : vt[i].e3);
      compare_ev($sformatf("vec%0d", i));
    end

    // credit and data raised together: credit message first
    ev_q.delete(); exp_q.delete(); dly = 1;
    cq.push_back('hABC); dq.push_back(8'h55);
    wait_idle("both");
    exp_q = '{'hFE, 'h15, 'h3C, EV_A, EV_R, 'h55};
    compare_ev("both");

    // escape pair with a pending byte behind it
    ev_q.delete(); exp_q.delete(); dly = 2;
    dq.push_back(8'hFE); dq.push_back(8'h41);
    wait_idle("pair");
    exp_q = '{EV_R, 'hFE, 'hFE, EV_R, 'h41};
    compare_ev("pair");

    // hold mid-pair; a stray tx_done while idle-requesting is ignored
    ev_q.delete(); exp_q.delete(); dly = 4;
    dq.push_back(8'hFE);
    n = 0;
    while (!tx_enable && n < 100) begin @(negedge clk); n++; end
    chk("hold_first_en", tx_enable, 1);
    tx_hold = 1;
    n = 0;
    while (ev_q.size() < 2 && n < 100) begin @(negedge clk); n++; end
    chk("hold_first_done", ev_q.size(), 2);
    repeat (6) begin
      @(negedge clk);
      chk("hold_en_low", tx_enable, 0);
    end
    chk("hold_busy", busy, 1);
    chk("hold_tx_data", tx_data, 'hFE);
    spur = 1; @(negedge clk); spur = 0;
    repeat (3) @(negedge clk);
    chk("spur_busy", busy, 1);
    tx_hold = 0;
    wait_idle("hold");
    exp_q = '{EV_R, 'hFE, 'hFE};
    compare_ev("hold");

    // reset during CRED_HI aborts without ack
    ev_q.delete(); exp_q.delete(); dly = 3;
    cq.push_back('hABC);
    n = 0;
    while (ev_q.size() < 1 && n < 100) begin @(negedge clk); n++; end
    n = 0;
    while (!tx_enable && n < 100) begin @(negedge clk); n++; end
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_tx_enable", tx_enable, 0);
    chk("mid_rst_tx_data", tx_data, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ack", credit_ack, 0);
    chk("mid_rst_ready", data_in_ready, 0);
    cq.delete();
    dq.push_back(8'h41);
    repeat (3) @(negedge clk);
    exp_q = '{'hFE};
    compare_ev("abort");
    ev_q.delete(); exp_q.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", data_in_ready, 1);
    wait_idle("post_rst");
    exp_data('h41);
    compare_ev("post_rst");

    // randomized batches: credits always drain before payload
    hold_rand = 1;
    for (int r = 0; r < 8; r++) begin
      ev_q.delete(); exp_q.delete();
      dly = $urandom_range(0, 6);
      nc = $urandom_range(0, 2);
      nd = $urandom_range(1, 4);
      for (int c = 0; c < nc; c++) begin
        v = $urandom_range(0, 4095);
        cq.push_back(v);
        exp_cred(v);
      end
      for (int d = 0; d < nd; d++) begin
        v = ($urandom_range(0, 3) == 0) ? 'hFE : $urandom_range(0, 255);
        dq.push_back(8'(v));
        exp_data(v);
      end
      wait_idle("rnd");
      compare_ev($sformatf("rnd%0d", r));
    end
    hold_rand = 0;
    tx_hold = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
